// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
// Contents: FSM state encoding, default timing parameters, interrupt line
// count and the lowest-index priority encoder used for interrupt selection.
package pipe_ctrl_pkg;

   localparam int IRQ_LINES        = 5;
   localparam int IRQ_ID_W         = 3;
   localparam int DEF_DRAIN_CYC    = 2;
   localparam int DEF_ALU_TIMEOUT  = 64;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_ALU_WAIT = 2'd1,
      ST_DRAIN    = 2'd2,
      ST_ENTER    = 2'd3
   } state_t;

   // Index of the lowest set bit; 0 when nothing is set.
   function automatic logic [IRQ_ID_W-1:0] lowest_set(input logic [IRQ_LINES-1:0] v);
      lowest_set = '0;
      for (int i = IRQ_LINES-1; i >= 0; i--) begin
         if (v[i]) lowest_set = IRQ_ID_W'(i);
      end
   endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle of the pipeline-side signals seen by pipe_ctrl.
// Latency: n/a (wiring only).
// Backpressure: n/a; stall/flush strobes are the pipeline's backpressure.
// Ports: master = pipeline stages (drive hazard/irq info, receive strobes);
//        slave  = pipe_ctrl (receives info, drives stall/flush/irq outputs).
interface pipe_ctrl_if;
   import pipe_ctrl_pkg::*;

   logic [4:0]           id_rs;
   logic [4:0]           id_rt;
   logic                 id_use_rs;
   logic                 id_use_rt;
   logic                 id_branch;
   logic                 ex_memread;
   logic [4:0]           ex_rt_rd;
   logic                 ex_multi;
   logic                 alu_ready;
   logic                 dmem_wait;
   logic [IRQ_LINES-1:0] interrupts;
   logic [IRQ_LINES-1:0] irq_mask;
   logic                 irq_en;

   logic                 IF_stall;
   logic                 ID_stall;
   logic                 EX_stall;
   logic                 M_stall;
   logic                 WB_stall;
   logic                 IF_flush;
   logic                 ID_flush;
   logic                 EX_flush;
   logic                 M_flush;
   logic                 irq_take;
   logic [IRQ_ID_W-1:0]  irq_id;
   logic                 alu_timeout;

   modport master (
      output id_rs, id_rt, id_use_rs, id_use_rt, id_branch, ex_memread, ex_rt_rd,
             ex_multi, alu_ready, dmem_wait, interrupts, irq_mask, irq_en,
      input  IF_stall, ID_stall, EX_stall, M_stall, WB_stall,
             IF_flush, ID_flush, EX_flush, M_flush, irq_take, irq_id, alu_timeout
   );

   modport slave (
      input  id_rs, id_rt, id_use_rs, id_use_rt, id_branch, ex_memread, ex_rt_rd,
             ex_multi, alu_ready, dmem_wait, interrupts, irq_mask, irq_en,
      output IF_stall, ID_stall, EX_stall, M_stall, WB_stall,
             IF_flush, ID_flush, EX_flush, M_flush, irq_take, irq_id, alu_timeout
   );

endinterface

// File: rtl/pipe_ctrl_irq_pend.sv
// Interrupt pending register with lowest-index priority selection.
// Latency: a line sampled at an edge is visible in any/id the next cycle.
// Backpressure: none; lines keep accumulating while the consumer is busy.
// Ports: clk, rst; interrupts/irq_mask in; clr_en/clr_id clear one bit;
//        any = some line pending, id = lowest pending index.
module pipe_ctrl_irq_pend
   import pipe_ctrl_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [IRQ_LINES-1:0] interrupts,
   input  logic [IRQ_LINES-1:0] irq_mask,
   input  logic                 clr_en,
   input  logic [IRQ_ID_W-1:0]  clr_id,
   output logic                 any,
   output logic [IRQ_ID_W-1:0]  id
);

   logic [IRQ_LINES-1:0] pending;
   logic [IRQ_LINES-1:0] clr;

   assign clr = clr_en ? (IRQ_LINES'(1) << clr_id) : '0;

   // Set is OR-ed in after the clear so a line still asserted re-arms at once.
   always_ff @(posedge clk) begin
      if (rst) pending <= '0;
      else     pending <= (pending & ~clr) | (interrupts & irq_mask);
   end

   assign any = |pending;
   assign id  = lowest_set(pending);

endmodule

// File: rtl/pipe_ctrl.sv
// Per-stage stall/flush sequencing: load-use, multi-cycle ALU hold, irq entry.
// Latency: stall/flush are combinational; irq_take follows DRAIN_CYC drain cycles.
// Backpressure: dmem_wait freezes the whole pipe and this FSM; pending still fills.
// Ports: clk, rst (sync, active-high); pc = slave side of pipe_ctrl_if.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int ALU_TIMEOUT = DEF_ALU_TIMEOUT,
   parameter int DRAIN_CYC   = DEF_DRAIN_CYC
)(
   input  logic        clk,
   input  logic        rst,
   pipe_ctrl_if.slave  pc
);

   localparam int CNT_MAX = (ALU_TIMEOUT > DRAIN_CYC) ? ALU_TIMEOUT : DRAIN_CYC;
   localparam int CW      = $clog2(CNT_MAX) + 1;
   localparam logic [CW-1:0] ALU_LAST   = CW'(ALU_TIMEOUT - 1);
   localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN_CYC - 1);

   state_t              state;
   logic [CW-1:0]       cnt;
   logic                take_q;
   logic [IRQ_ID_W-1:0] id_q;
   logic                tout_q;

   logic                pend_any;
   logic [IRQ_ID_W-1:0] pend_id;
   logic                hazard;
   logic                alu_start;
   logic                alu_hold;
   logic                irq_start;
   logic                take;

   assign hazard = pc.ex_memread && (pc.ex_rt_rd != 5'd0) &&
                   ((pc.id_use_rs && (pc.id_rs == pc.ex_rt_rd)) ||
                    (pc.id_use_rt && (pc.id_rt == pc.ex_rt_rd)));

   // The detecting RUN cycle already holds the pipe so the multi-cycle op
   // cannot slip out of EX before its result exists.
   assign alu_start = pc.ex_multi && !pc.alu_ready;
   assign alu_hold  = ((state == ST_RUN) && alu_start) ||
                      ((state == ST_ALU_WAIT) && !pc.alu_ready);
   // Never start while ID holds a branch: its delay slot must not be split.
   assign irq_start = pc.irq_en && pend_any && !pc.id_branch && !hazard;
   assign take      = take_q && !pc.dmem_wait;

   pipe_ctrl_irq_pend u_irq_pend (
      .clk        (clk),
      .rst        (rst),
      .interrupts (pc.interrupts),
      .irq_mask   (pc.irq_mask),
      .clr_en     (take),
      .clr_id     (id_q),
      .any        (pend_any),
      .id         (pend_id)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_RUN;
         cnt    <= '0;
         take_q <= 1'b0;
         id_q   <= '0;
         tout_q <= 1'b0;
      end else if (!pc.dmem_wait) begin
         case (state)
            ST_RUN: begin
               if (alu_start) begin
                  state <= ST_ALU_WAIT;
                  cnt   <= '0;
               end else if (irq_start) begin
                  state <= ST_DRAIN;
                  cnt   <= DRAIN_LOAD;
               end
            end
            ST_ALU_WAIT: begin
               if (pc.alu_ready) begin
                  state <= ST_RUN;
               end else if (cnt == ALU_LAST) begin
                  tout_q <= 1'b1;
                  state  <= ST_RUN;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            ST_DRAIN: begin
               if (cnt == '0) begin
                  state  <= ST_ENTER;
                  take_q <= 1'b1;
                  id_q   <= pend_id;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            ST_ENTER: begin
               state  <= ST_RUN;
               take_q <= 1'b0;
               id_q   <= '0;
            end
            default: state <= ST_RUN;
         endcase
      end
   end

   // Strobes in priority order: dmem_wait, ALU hold, drain/enter, load-use.
   always_comb begin
      pc.IF_stall = 1'b0;
      pc.ID_stall = 1'b0;
      pc.EX_stall = 1'b0;
      pc.M_stall  = 1'b0;
      pc.IF_flush = 1'b0;
      pc.ID_flush = 1'b0;
      pc.EX_flush = 1'b0;
      if (pc.dmem_wait) begin
         pc.IF_stall = 1'b1;
         pc.ID_stall = 1'b1;
         pc.EX_stall = 1'b1;
         pc.M_stall  = 1'b1;
      end else if (alu_hold) begin
         pc.IF_stall = 1'b1;
         pc.ID_stall = 1'b1;
         pc.EX_flush = 1'b1;
      end else if (state == ST_DRAIN) begin
         pc.IF_stall = 1'b1;
         pc.ID_flush = 1'b1;
      end else if (state == ST_ENTER) begin
         pc.IF_flush = 1'b1;
         pc.ID_flush = 1'b1;
      end else if (hazard) begin
         pc.IF_stall = 1'b1;
         pc.ID_stall = 1'b1;
         pc.ID_flush = 1'b1;
      end
   end

   assign pc.WB_stall    = 1'b0;
   assign pc.M_flush     = 1'b0;
   assign pc.irq_take    = take;
   assign pc.irq_id      = id_q;
   assign pc.alu_timeout = tout_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed-vector bench for pipe_ctrl.
// Latency: inputs driven on negedge, outputs compared 1 time unit later.
// Backpressure: dmem_wait exercised as a stimulus field.
module tb_pipe_ctrl;

   typedef struct packed {
      logic       rst;
      logic [4:0] id_rs;
      logic [4:0] id_rt;
      logic       id_use_rs;
      logic       id_use_rt;
      logic       id_branch;
      logic       ex_memread;
      logic [4:0] ex_rt_rd;
      logic       ex_multi;
      logic       alu_ready;
      logic       dmem_wait;
      logic [4:0] interrupts;
      logic [4:0] irq_mask;
      logic       irq_en;
   } in_t;

   typedef struct {
      in_t         i;
      logic [13:0] exp;
      bit          chk;
   } vec_t;

   // Output bit positions in the observed vector.
   localparam logic [13:0] B_IFS  = 14'h2000;
   localparam logic [13:0] B_IDS  = 14'h1000;
   localparam logic [13:0] B_EXS  = 14'h0800;
   localparam logic [13:0] B_MS   = 14'h0400;
   localparam logic [13:0] B_IFF  = 14'h0100;
   localparam logic [13:0] B_IDF  = 14'h0080;
   localparam logic [13:0] B_EXF  = 14'h0040;
   localparam logic [13:0] B_TAKE = 14'h0010;
   localparam logic [13:0] B_TOUT = 14'h0001;
   localparam logic [13:0] HAZ    = B_IFS | B_IDS | B_IDF;
   localparam logic [13:0] ALU    = B_IFS | B_IDS | B_EXF;
   localparam logic [13:0] DRN    = B_IFS | B_IDF;
   localparam logic [13:0] DMW    = B_IFS | B_IDS | B_EXS | B_MS;
   localparam logic [13:0] NONE   = 14'h0000;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pipe_ctrl_if ifc ();

   pipe_ctrl #(.ALU_TIMEOUT(64), .DRAIN_CYC(2)) dut (
      .clk (clk),
      .rst (rst),
      .pc  (ifc.slave)
   );

   logic [13:0] obs;
   assign obs = {ifc.IF_stall, ifc.ID_stall, ifc.EX_stall, ifc.M_stall, ifc.WB_stall,
                 ifc.IF_flush, ifc.ID_flush, ifc.EX_flush, ifc.M_flush,
                 ifc.irq_take, ifc.irq_id, ifc.alu_timeout};

   vec_t vecs[$];
   int   napplied = 0;
   int   nfail    = 0;

   function automatic in_t idle();
      in_t r;
      r          = '0;
      r.irq_mask = 5'b11111;
      r.irq_en   = 1'b1;
      return r;
   endfunction

   function automatic logic [13:0] ent(input int id);
      return B_IFF | B_IDF | B_TAKE | 14'(id << 1);
   endfunction

   task automatic add(input in_t i, input logic [13:0] e, input bit c = 1'b1);
      vec_t v;
      v.i   = i;
      v.exp = e;
      v.chk = c;
      vecs.push_back(v);
   endtask

   task automatic apply(input in_t i, input logic [13:0] e, input bit c, input int idx);
      @(negedge clk);
      rst            = i.rst;
      ifc.id_rs      = i.id_rs;
      ifc.id_rt      = i.id_rt;
      ifc.id_use_rs  = i.id_use_rs;
      ifc.id_use_rt  = i.id_use_rt;
      ifc.id_branch  = i.id_branch;
      ifc.ex_memread = i.ex_memread;
      ifc.ex_rt_rd   = i.ex_rt_rd;
      ifc.ex_multi   = i.ex_multi;
      ifc.alu_ready  = i.alu_ready;
      ifc.dmem_wait  = i.dmem_wait;
      ifc.interrupts = i.interrupts;
      ifc.irq_mask   = i.irq_mask;
      ifc.irq_en     = i.irq_en;
      #1;
      if (c) begin
         napplied++;
         if (obs !== e) begin
            nfail++;
            $display("FAIL vec %0d: outputs got %b expected %b", idx, obs, e);
         end
      end
   endtask

   initial begin
      in_t t;
      rst = 1'b1;
      ifc.id_rs = '0; ifc.id_rt = '0; ifc.id_use_rs = 1'b0; ifc.id_use_rt = 1'b0;
      ifc.id_branch = 1'b0; ifc.ex_memread = 1'b0; ifc.ex_rt_rd = '0;
      ifc.ex_multi = 1'b0; ifc.alu_ready = 1'b0; ifc.dmem_wait = 1'b0;
      ifc.interrupts = '0; ifc.irq_mask = '0; ifc.irq_en = 1'b0;

      // Reset and reset state.
      t = idle(); t.rst = 1'b1; add(t, NONE, 1'b0);
      t = idle(); add(t, NONE);
      // Load-use on rs, then load has advanced.
      t = idle(); t.ex_memread = 1; t.ex_rt_rd = 5; t.id_rs = 5; t.id_use_rs = 1; add(t, HAZ);
      t = idle(); add(t, NONE);
      // Destination r0 never hazards.
      t = idle(); t.ex_memread = 1; t.ex_rt_rd = 0; t.id_rs = 0; t.id_use_rs = 1; add(t, NONE);
      // Load-use on rt; then rt not actually read; then not a load.
      t = idle(); t.ex_memread = 1; t.ex_rt_rd = 7; t.id_rt = 7; t.id_use_rt = 1;
      t.id_rs = 3; t.id_use_rs = 1; add(t, HAZ);
      t.id_use_rt = 0; add(t, NONE);
      t.id_use_rt = 1; t.ex_memread = 0; add(t, NONE);
      // dmem_wait overrides a hazard.
      t = idle(); t.ex_memread = 1; t.ex_rt_rd = 5; t.id_rs = 5; t.id_use_rs = 1;
      t.dmem_wait = 1; add(t, DMW);
      // ALU wait 4 cycles, released when ready.
      t = idle(); t.ex_multi = 1;
      repeat (4) add(t, ALU);
      t.alu_ready = 1; add(t, NONE);
      t = idle(); add(t, NONE);
      // Two interrupts, lowest first.
      t = idle(); t.interrupts = 5'b10100; add(t, NONE);
      t = idle(); add(t, NONE); add(t, DRN); add(t, DRN); add(t, ent(2));
      add(t, NONE); add(t, DRN); add(t, DRN); add(t, ent(4)); add(t, NONE); add(t, NONE);
      // Masked line never becomes pending.
      t = idle(); t.interrupts = 5'b00001; t.irq_mask = 5'b11110; add(t, NONE);
      t = idle(); add(t, NONE); add(t, NONE); add(t, NONE);
      // Global enable off holds the line pending until enabled.
      t = idle(); t.interrupts = 5'b00100; t.irq_en = 0; add(t, NONE);
      t.interrupts = 5'b00000; add(t, NONE); add(t, NONE);
      t = idle(); add(t, NONE); add(t, DRN); add(t, DRN); add(t, ent(2)); add(t, NONE);
      // Branch in ID blocks drain start.
      t = idle(); t.interrupts = 5'b00010; t.id_branch = 1; add(t, NONE);
      t.interrupts = 5'b00000; add(t, NONE); add(t, NONE);
      t = idle(); add(t, NONE); add(t, DRN); add(t, DRN); add(t, ent(1)); add(t, NONE);
      // dmem_wait during DRAIN freezes the countdown.
      t = idle(); t.interrupts = 5'b00001; add(t, NONE);
      t = idle(); add(t, NONE); add(t, DRN);
      t.dmem_wait = 1; add(t, DMW); add(t, DMW);
      t = idle(); add(t, DRN); add(t, ent(0)); add(t, NONE);
      // rst during ALU_WAIT.
      t = idle(); t.ex_multi = 1; add(t, ALU); add(t, ALU);
      t.rst = 1; add(t, NONE, 1'b0);
      t = idle(); add(t, NONE); add(t, NONE);
      // rst at the end of DRAIN clears pending: no take afterwards.
      t = idle(); t.interrupts = 5'b00001; add(t, NONE);
      t = idle(); add(t, NONE); add(t, DRN);
      t.rst = 1; add(t, NONE, 1'b0);
      t = idle(); repeat (4) add(t, NONE);

      foreach (vecs[k]) apply(vecs[k].i, vecs[k].exp, vecs[k].chk, k);

      // ALU timeout: 1 detect cycle plus 64 wait cycles, then sticky flag.
      t = idle(); t.rst = 1; apply(t, NONE, 1'b0, 1000);
      t = idle(); apply(t, NONE, 1'b1, 1001);
      t.ex_multi = 1;
      for (int c = 0; c <= 64; c++) apply(t, ALU, 1'b1, 1100 + c);
      t = idle();
      for (int c = 0; c < 4; c++) apply(t, B_TOUT, 1'b1, 1200 + c);
      t.rst = 1; apply(t, B_TOUT, 1'b0, 1300);
      t = idle(); apply(t, NONE, 1'b1, 1301);

      $display("== %0d vectors applied, %0d miscompares ==", napplied, nfail);
      $finish;
   end

endmodule
